// File: rtl/spi_master.sv
// SPI mode-0 master (CPOL=0, CPHA=0, MSB first, 8-bit frames) with a byte-level
// valid/ready host interface and multi-byte messages framed by ssel.
module spi_master #(
    parameter int CLK_DIV  = 8,
    parameter int CS_SETUP = 4,
    parameter int CS_HOLD  = 4,
    parameter int CS_IDLE  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_byte,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    input  logic       stop,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       busy,
    output logic       sck,
    output logic       mosi,
    input  logic       miso,
    output logic       ssel
);

    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int SETUP_W = $clog2(CS_SETUP + 1);
    localparam int HOLD_W  = $clog2(CS_HOLD + 1);
    localparam int GAP_W   = $clog2(CS_IDLE + 1);

    localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [SETUP_W-1:0] SETUP_LAST = SETUP_W'(CS_SETUP - 1);
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(CS_HOLD - 1);
    localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'(CS_IDLE - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        WAIT  = 3'd3,
        HOLD  = 3'd4,
        GAP   = 3'd5
    } state_t;

    state_t             state;
    logic [7:0]         tx_sr;
    logic [7:0]         rx_sr;
    logic               last_q;
    logic [DIV_W-1:0]   div_cnt;
    logic [2:0]         bit_cnt;
    logic [SETUP_W-1:0] setup_cnt;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [GAP_W-1:0]   gap_cnt;
    logic               accept;

    // Handshake: a byte moves when tx_valid && tx_ready in the same cycle;
    // tx_ready is a registered flag that is high only in IDLE and WAIT.
    assign accept = tx_valid && tx_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sck       <= 1'b0;
            mosi      <= 1'b0;
            ssel      <= 1'b1;
            rx_byte   <= 8'h00;
            rx_valid  <= 1'b0;
            busy      <= 1'b0;
            tx_ready  <= 1'b1;
            tx_sr     <= 8'h00;
            rx_sr     <= 8'h00;
            last_q    <= 1'b0;
            div_cnt   <= '0;
            bit_cnt   <= 3'd0;
            setup_cnt <= '0;
            hold_cnt  <= '0;
            gap_cnt   <= '0;
        end else begin
            rx_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        tx_sr     <= tx_byte;
                        last_q    <= tx_last;
                        mosi      <= tx_byte[7];
                        ssel      <= 1'b0;
                        setup_cnt <= '0;
                        busy      <= 1'b1;
                        tx_ready  <= 1'b0;
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    if (setup_cnt == SETUP_LAST) begin
                        div_cnt <= '0;
                        bit_cnt <= 3'd0;
                        state   <= SHIFT;
                    end else begin
                        setup_cnt <= setup_cnt + 1'b1;
                    end
                end
                SHIFT: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        if (!sck) begin
                            sck   <= 1'b1;
                            rx_sr <= {rx_sr[6:0], miso};
                        end else begin
                            sck <= 1'b0;
                            if (bit_cnt == 3'd7) begin
                                // Final falling edge: publish the byte, keep mosi on bit 0.
                                rx_byte  <= rx_sr;
                                rx_valid <= 1'b1;
                                if (last_q) begin
                                    hold_cnt <= '0;
                                    state    <= HOLD;
                                end else begin
                                    tx_ready <= 1'b1;
                                    state    <= WAIT;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                                mosi    <= tx_sr[6];
                                tx_sr   <= {tx_sr[6:0], 1'b0};
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                WAIT: begin
                    if (accept) begin
                        tx_sr    <= tx_byte;
                        last_q   <= tx_last;
                        mosi     <= tx_byte[7];
                        div_cnt  <= '0;
                        bit_cnt  <= 3'd0;
                        tx_ready <= 1'b0;
                        state    <= SHIFT;
                    end else if (stop) begin
                        hold_cnt <= '0;
                        tx_ready <= 1'b0;
                        state    <= HOLD;
                    end
                end
                HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        ssel    <= 1'b1;
                        gap_cnt <= '0;
                        state   <= GAP;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        busy     <= 1'b0;
                        tx_ready <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: begin
                    sck      <= 1'b0;
                    ssel     <= 1'b1;
                    busy     <= 1'b0;
                    tx_ready <= 1'b1;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
SPI mode-0 master (CPOL=0, CPHA=0, MSB first, 8-bit frames) that drives the external SPI bus to the eink controller's SPI slave port, or to other SPI peripherals such as flash or PMIC. A host FSM hands bytes over a valid/ready handshake. The block asserts ssel, clocks the byte out on mosi, and returns the byte captured from miso. Multi-byte messages keep ssel low between bytes until the host marks the last byte or issues stop.

Parameters:
CLK_DIV, 8, sck half-period in clk cycles; legal range >= 6 so that an oversampling slave can turn miso around
CS_SETUP, 4, clk cycles from ssel falling to the first sck rising edge
CS_HOLD, 4, clk cycles from the last sck falling edge of a message to ssel rising
CS_IDLE, 4, minimum clk cycles ssel stays high between messages

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
tx_byte  input  8  byte to transmit; sampled on handshake
tx_valid  input  1  host offers tx_byte
tx_last  input  1  sampled with tx_byte; 1 = final byte of message
tx_ready  output  1  block accepts a byte this cycle
stop  input  1  in WAIT, closes the message without sending a byte
rx_byte  output  8  last byte received from miso
rx_valid  output  1  one-cycle pulse; rx_byte is new
busy  output  1  high in every state except IDLE
sck  output  1  SPI clock, idle low
mosi  output  1  SPI data out
miso  input  1  SPI data in
ssel  output  1  SPI chip select, active low

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE, sck=0, mosi=0, ssel=1, rx_byte=0x00, rx_valid=0, busy=0, tx_ready=1. Reset during a transfer releases ssel immediately, with no rx_valid pulse.
- States: IDLE, SETUP, SHIFT, WAIT, HOLD, GAP.
- tx_ready=1 only in IDLE and WAIT. A byte is accepted when tx_valid && tx_ready. tx_valid in other states is ignored.
- IDLE, on accept: latch tx_byte into the shift register, latch tx_last, then go to SETUP. In the next cycle ssel=0 and mosi=tx_byte[7].
- SETUP: count CS_SETUP cycles with sck=0, then go to SHIFT.
- SHIFT: each of the 8 bits is CLK_DIV cycles with sck=0, then CLK_DIV cycles with sck=1.
  - On the sck 0->1 transition, sample miso into the LSB of the rx shift register.
  - On the sck 1->0 transition of bits 1..7, mosi takes the next bit.
  - After the 8th falling edge: rx_byte is updated and rx_valid pulses for exactly 1 cycle. Next state is HOLD if the latched tx_last=1, otherwise WAIT.
  - Byte time is 16*CLK_DIV cycles. From accept in IDLE to the rx_valid cycle takes 1 + CS_SETUP + 16*CLK_DIV cycles.
- WAIT: ssel=0, sck=0, mosi holds the last bit; the block waits indefinitely.
  - Accept → latch the new byte and go directly to SHIFT (no CS_SETUP). mosi=new bit7 in the next cycle.
  - stop=1 with no accept → HOLD. If tx_valid and stop are both high, the byte wins and stop is ignored.
- HOLD: CS_HOLD cycles with ssel=0 and sck=0, then ssel=1 and go to GAP.
- GAP: CS_IDLE cycles with ssel=1, then go to IDLE. A new message therefore cannot lower ssel earlier than CS_IDLE cycles after ssel rose.
- Counters:
  - Divider counter is ceil(log2(CLK_DIV)) bits and wraps at CLK_DIV-1.
  - Bit counter is 3 bits. SHIFT exits when it reaches 7 at a falling edge.
  - Setup, hold and gap counters are each sized for their parameter.
- sck toggles only in SHIFT. sck, mosi and ssel are driven directly from flops (glitch-free).
- rx_byte holds its value until the next rx_valid.

Test Plan:
- Single byte, CLK_DIV=8, CS_SETUP=4: send 0xA5 with tx_last=1 while the miso model returns 0x3C → mosi is 1,0,1,0,0,1,0,1 at the 8 sck rising edges; rx_valid is 1 cycle at accept+133 with rx_byte=0x3C; ssel rises 4 cycles after the 8th falling edge; busy=0 after the GAP.
- Three-byte burst 0x01,0x02,0x03 (last on 0x03) → ssel stays low across all 24 sck pulses; there is no SETUP delay between bytes; three rx_valid pulses; exactly one ssel low window.
- WAIT with stop → send 0x55 with tx_last=0, idle for 50 cycles (ssel stays 0, sck stays 0), then pulse stop → HOLD then GAP; no extra sck edges.
- Simultaneous tx_valid and stop in WAIT → the byte is accepted and 8 more sck pulses occur; stop has no effect.
- rst_n low mid-byte (after the 3rd rising edge) → ssel=1, sck=0, busy=0, no rx_valid; after rst_n goes high a fresh 0xFF transfer completes normally.
- tx_valid held high during SHIFT/HOLD/GAP → tx_ready=0 and no byte is lost or duplicated; the next byte is accepted only in IDLE, at least CS_IDLE cycles after ssel rose.
